// File: rtl/uart_pkg.sv
// Shared types for the UART packet controller: parser states, error codes, char framing.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        HUNT,
        LEN,
        PAYLOAD,
        CHECK,
        DRAIN
    } pkt_state_t;

    typedef enum logic [2:0] {
        ERR_NONE = 3'd0,
        ERR_LEN  = 3'd1,
        ERR_CHK  = 3'd2,
        ERR_OVF  = 3'd3,
        ERR_TMO  = 3'd4
    } err_code_t;

    // Start + 8 data + stop bits per character.
    localparam int UART_CHAR_BITS = 10;

    // The receiver cannot sample with fewer than two clocks per bit.
    function automatic logic [31:0] clamp_cpb(input logic [31:0] v);
        return (v < 32'd2) ? 32'd2 : v;
    endfunction

endpackage

// File: rtl/uart_rx_pkt_ctrl_if.sv
// Bundle of the receiver-side, config and payload-stream signals of the packet controller.
// Latency: n/a (wiring only).
// Backpressure: outValid/outReady handshake on the payload stream; rx side has none.
interface uart_rx_pkt_ctrl_if;
    logic        cfgWrite;
    logic [31:0] cfgClocksPerBit;
    logic [31:0] clocksPerBit;
    logic        rxDv;
    logic [7:0]  rxByte;
    logic        outValid;
    logic        outReady;
    logic [7:0]  outByte;
    logic        outLast;
    logic        pktDone;
    logic        errPulse;
    logic [2:0]  errCode;

    // Environment side: feeds bytes/config, consumes the payload stream.
    modport master (
        output cfgWrite, cfgClocksPerBit, rxDv, rxByte, outReady,
        input  clocksPerBit, outValid, outByte, outLast, pktDone, errPulse, errCode
    );

    // Controller side.
    modport slave (
        input  cfgWrite, cfgClocksPerBit, rxDv, rxByte, outReady,
        output clocksPerBit, outValid, outByte, outLast, pktDone, errPulse, errCode
    );
endinterface

// File: rtl/uart_byte_buf.sv
// Payload buffer: DEPTH x 8 register file, one write port, one combinational read port.
// Latency: write visible on the read port the cycle after the write edge; read is 0-cycle.
// Backpressure: none; the caller owns addressing and flow.
module uart_byte_buf #(
    parameter int DEPTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [7:0]    i_wdat,
    input  logic [AW-1:0] i_raddr,
    output logic [7:0]    o_rdat
);

    logic [7:0] r_mem [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdat;
        end
    end

    assign o_rdat = r_mem[i_raddr];

endmodule

// File: rtl/uart_rx_pkt_ctrl.sv
// Frames [SYNC][LEN][payload][CHK] from the UART receiver, checks the checksum, streams good payloads.
// Latency: first payload byte valid 1 cycle after CHK is sampled; errors pulse 1 cycle after the bad byte.
// Backpressure: outByte/outLast held while outReady low; rx bytes arriving during drain are dropped (ERR_OVF).
// Optional inter-byte timeout when UART_RX_TIMEOUT_EN is defined.
module uart_rx_pkt_ctrl
    import uart_pkg::*;
#(
    parameter int          MAX_PAYLOAD   = 16,
    parameter logic [7:0]  SYNC_BYTE     = 8'hA5,
    parameter logic [31:0] DEFAULT_CPB   = 32'd868,
    parameter int          TIMEOUT_CHARS = 4
) (
    input  logic              clk,
    input  logic              rstN,
    uart_rx_pkt_ctrl_if.slave bus
);

    localparam logic [7:0] MAX_LEN = 8'(MAX_PAYLOAD);
    localparam int         BUF_AW  = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

    pkt_state_t  r_state, w_next;
    logic [7:0]  r_len, r_idx, r_rd_idx, r_sum;
    logic [31:0] r_cpb, r_cfg_val;
    logic        r_cfg_pend;
    logic        r_err_vld;
    err_code_t   r_err_code, w_err_code;
    logic        w_err_vld, w_buf_we, w_drain, w_hs, w_last, w_tmo_hit;
    logic [7:0]  w_rd_dat, w_chk_sum;

    uart_byte_buf #(.DEPTH(MAX_PAYLOAD), .AW(BUF_AW)) u_buf (
        .clk     (clk),
        .i_we    (w_buf_we),
        .i_waddr (r_idx[BUF_AW-1:0]),
        .i_wdat  (bus.rxByte),
        .i_raddr (r_rd_idx[BUF_AW-1:0]),
        .o_rdat  (w_rd_dat)
    );

    assign w_drain   = (r_state == DRAIN);
    assign w_hs      = w_drain && bus.outReady;
    assign w_last    = (r_rd_idx == r_len - 8'd1);
    assign w_chk_sum = r_sum + bus.rxByte;

`ifdef UART_RX_TIMEOUT_EN
    logic [39:0] r_tmo_cnt;
    logic [39:0] w_tmo_limit;
    logic        w_tmo_active;

    assign w_tmo_limit  = 40'(r_cpb) * 40'(TIMEOUT_CHARS * UART_CHAR_BITS);
    assign w_tmo_active = (r_state == LEN) || (r_state == PAYLOAD) || (r_state == CHECK);
    // Fires on the edge where the silence since the last byte reaches the limit.
    assign w_tmo_hit    = w_tmo_active && !bus.rxDv && (r_tmo_cnt + 40'd1 >= w_tmo_limit);

    // Silence counter: restarts on every byte and idles outside the framing states.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_tmo_cnt <= '0;
        end else if (bus.rxDv || !w_tmo_active) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + 40'd1;
        end
    end
`else
    logic w_unused_tmo;
    assign w_unused_tmo = ^TIMEOUT_CHARS;
    assign w_tmo_hit    = 1'b0;
`endif

    // Parser state register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) r_state <= HUNT;
        else       r_state <= w_next;
    end

    // Next-state decode plus buffer write enable and error cause.
    always_comb begin
        w_next     = r_state;
        w_err_vld  = 1'b0;
        w_err_code = ERR_NONE;
        w_buf_we   = 1'b0;
        case (r_state)
            HUNT: begin
                if (bus.rxDv && bus.rxByte == SYNC_BYTE) w_next = LEN;
            end
            LEN: begin
                if (bus.rxDv) begin
                    if (bus.rxByte == 8'd0 || bus.rxByte > MAX_LEN) begin
                        w_err_vld  = 1'b1;
                        w_err_code = ERR_LEN;
                        w_next     = HUNT;
                    end else begin
                        w_next = PAYLOAD;
                    end
                end
            end
            PAYLOAD: begin
                if (bus.rxDv) begin
                    w_buf_we = 1'b1;
                    if (r_idx == r_len - 8'd1) w_next = CHECK;
                end
            end
            CHECK: begin
                if (bus.rxDv) begin
                    if (w_chk_sum == 8'd0) begin
                        w_next = DRAIN;
                    end else begin
                        w_err_vld  = 1'b1;
                        w_err_code = ERR_CHK;
                        w_next     = HUNT;
                    end
                end
            end
            DRAIN: begin
                if (bus.rxDv) begin
                    w_err_vld  = 1'b1;
                    w_err_code = ERR_OVF;
                end
                if (w_hs && w_last) w_next = HUNT;
            end
            default: w_next = HUNT;
        endcase
        if (w_tmo_hit) begin
            w_err_vld  = 1'b1;
            w_err_code = ERR_TMO;
            w_next     = HUNT;
        end
    end

    // Length, running checksum and write/read indices.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_len    <= '0;
            r_idx    <= '0;
            r_sum    <= '0;
            r_rd_idx <= '0;
        end else begin
            if (bus.rxDv) begin
                case (r_state)
                    LEN: begin
                        r_len <= bus.rxByte;
                        r_sum <= bus.rxByte;
                        r_idx <= '0;
                    end
                    PAYLOAD: begin
                        r_sum <= w_chk_sum;
                        r_idx <= r_idx + 8'd1;
                    end
                    CHECK:   r_rd_idx <= '0;
                    default: ;
                endcase
            end
            if (w_hs) r_rd_idx <= r_rd_idx + 8'd1;
        end
    end

    // Bit-period config: immediate in HUNT, otherwise parked until HUNT is re-entered (last write wins).
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_cpb      <= DEFAULT_CPB;
            r_cfg_val  <= DEFAULT_CPB;
            r_cfg_pend <= 1'b0;
        end else if (r_state == HUNT) begin
            if (bus.cfgWrite) r_cpb <= clamp_cpb(bus.cfgClocksPerBit);
            r_cfg_pend <= 1'b0;
        end else begin
            if (bus.cfgWrite) begin
                r_cfg_val  <= bus.cfgClocksPerBit;
                r_cfg_pend <= 1'b1;
            end
            if (w_next == HUNT) begin
                if (bus.cfgWrite)     r_cpb <= clamp_cpb(bus.cfgClocksPerBit);
                else if (r_cfg_pend)  r_cpb <= clamp_cpb(r_cfg_val);
                r_cfg_pend <= 1'b0;
            end
        end
    end

    // One-cycle error pulse; the code reads ERR_NONE between pulses.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_err_vld  <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_err_vld  <= w_err_vld;
            r_err_code <= w_err_vld ? w_err_code : ERR_NONE;
        end
    end

    assign bus.clocksPerBit = r_cpb;
    assign bus.outValid     = w_drain;
    assign bus.outByte      = w_drain ? w_rd_dat : 8'd0;
    assign bus.outLast      = w_drain && w_last;
    assign bus.pktDone      = w_hs && w_last;
    assign bus.errPulse     = r_err_vld;
    assign bus.errCode      = r_err_code;

endmodule
